// File: rtl/seq_det_pkg.sv
// rtl/seq_det_pkg.sv - shared state type and default pattern for the shared sequence detector
package seq_det_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      LOAD   = 2'd1,
      SCAN   = 2'd2,
      REPORT = 2'd3
   } sched_state_t;

   localparam logic [11:0] SEQ_PAT_DEFAULT = 12'b111011011011;

endpackage

// File: rtl/seq_det_sched_pat_match_core.sv
// rtl/seq_det_sched_pat_match_core.sv - serial history, fill gating, pattern compare and saturating match count
module pat_match_core #(
   parameter int PAT_W = 12,
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clear,
   input  logic             shift_en,
   input  logic             bit_in,
   input  logic [PAT_W-1:0] pattern,
   output logic             hit,
   output logic [CNT_W-1:0] count
);

   localparam int FILL_W = $clog2(PAT_W + 1);

   logic [PAT_W-1:0]  hist;
   logic [PAT_W-1:0]  hist_nxt;
   logic [FILL_W-1:0] fill;
   logic [FILL_W-1:0] fill_nxt;

   // The newest bit enters at the LSB, so the MSB is the oldest bit and
   // lines up with pattern[PAT_W-1]; the match looks at the updated history.
   always_comb begin
      hist_nxt = {hist[PAT_W-2:0], bit_in};
      fill_nxt = (fill == FILL_W'(PAT_W)) ? fill : fill + 1'b1;
      hit      = shift_en && (fill_nxt == FILL_W'(PAT_W)) && (hist_nxt == pattern);
   end

   // History, fill level and match count; cleared at the start of every job.
   always_ff @(posedge clk) begin
      if (reset || clear) begin
         hist  <= '0;
         fill  <= '0;
         count <= '0;
      end else if (shift_en) begin
         hist <= hist_nxt;
         fill <= fill_nxt;
         if (hit && (count != '1)) begin
            count <= count + 1'b1;
         end
      end
   end

endmodule

// File: rtl/seq_det_sched.sv
// rtl/seq_det_sched.sv - round-robin sharing of one pattern matcher; SEQ_DET_SCHED_FIRST_POS_EN adds first_pos
module seq_det_sched
   import seq_det_pkg::*;
#(
   parameter int               N_REQ    = 4,
   parameter int               PAT_W    = 12,
   parameter logic [PAT_W-1:0] PAT_RST  = PAT_W'(SEQ_PAT_DEFAULT),
   parameter int               SCAN_LEN = 64,
   parameter int               CNT_W    = 8
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         cfg_we,
   input  logic [PAT_W-1:0]             cfg_pat,
   input  logic [N_REQ-1:0]             req,
   input  logic [N_REQ-1:0]             bit_in,
   output logic [N_REQ-1:0]             gnt,
   output logic                         busy,
   output logic                         done,
   output logic [$clog2(N_REQ)-1:0]     done_id,
   output logic [CNT_W-1:0]             match_cnt,
`ifdef SEQ_DET_SCHED_FIRST_POS_EN
   output logic [$clog2(SCAN_LEN+1)-1:0] first_pos,
`endif
   output logic                         aborted
);

   localparam int ID_W  = $clog2(N_REQ);
   localparam int POS_W = $clog2(SCAN_LEN + 1);

   sched_state_t     state;
   sched_state_t     state_nxt;
   logic [ID_W-1:0]  last;
   logic [ID_W-1:0]  pick;
   logic             found;
   logic [PAT_W-1:0] shadow;
   logic [PAT_W-1:0] active;
   logic [POS_W-1:0] scan_cnt;
   logic             scan_last;
   logic             consume;
   logic [ID_W-1:0]  rep_id;
   logic             rep_ab;
   logic [CNT_W-1:0] rep_cnt;
   logic             core_hit;
   logic [CNT_W-1:0] core_cnt;

   assign scan_last = (scan_cnt == POS_W'(SCAN_LEN - 1));
   assign consume   = (state == SCAN) && req[last];

   // Round-robin search starting one past the previous winner.
   always_comb begin
      pick  = last;
      found = 1'b0;
      for (int i = 1; i <= N_REQ; i++) begin
         if (!found && req[(int'(last) + i) % N_REQ]) begin
            pick  = ID_W'((int'(last) + i) % N_REQ);
            found = 1'b1;
         end
      end
   end

   // FSM state register.
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // FSM next state; a dropped request ends the scan without consuming the bit.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (found) state_nxt = LOAD;
         LOAD:    state_nxt = SCAN;
         SCAN:    if (!req[last] || scan_last) state_nxt = REPORT;
         REPORT:  state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Winner register doubles as the round-robin pointer; reset favours channel 0.
   always_ff @(posedge clk) begin
      if (reset) begin
         last <= ID_W'(N_REQ - 1);
      end else if ((state == IDLE) && found) begin
         last <= pick;
      end
   end

   // Shadow takes writes at any time; the matcher only sees it after LOAD.
   always_ff @(posedge clk) begin
      if (reset) begin
         shadow <= PAT_RST;
         active <= PAT_RST;
      end else begin
         if (cfg_we) shadow <= cfg_pat;
         if (state == LOAD) active <= shadow;
      end
   end

   // Count of bits consumed in the current job.
   always_ff @(posedge clk) begin
      if (reset || (state == LOAD)) begin
         scan_cnt <= '0;
      end else if (consume) begin
         scan_cnt <= scan_cnt + 1'b1;
      end
   end

   // Owner and abort flag are latched on the way into REPORT; the count is
   // latched during REPORT so it holds while the next job runs.
   always_ff @(posedge clk) begin
      if (reset) begin
         rep_id  <= '0;
         rep_ab  <= 1'b0;
         rep_cnt <= '0;
      end else begin
         if ((state == SCAN) && (state_nxt == REPORT)) begin
            rep_id <= last;
            rep_ab <= !req[last];
         end
         if (state == REPORT) rep_cnt <= core_cnt;
      end
   end

   pat_match_core #(
      .PAT_W (PAT_W),
      .CNT_W (CNT_W)
   ) u_core (
      .clk      (clk),
      .reset    (reset),
      .clear    (state == LOAD),
      .shift_en (consume),
      .bit_in   (bit_in[last]),
      .pattern  (active),
      .hit      (core_hit),
      .count    (core_cnt)
   );

`ifdef SEQ_DET_SCHED_FIRST_POS_EN
   logic [POS_W-1:0] fp_q;
   logic [POS_W-1:0] rep_fp;

   // First matching SCAN cycle (1-based); zero means no match yet.
   always_ff @(posedge clk) begin
      if (reset) begin
         fp_q   <= '0;
         rep_fp <= '0;
      end else begin
         if (state == LOAD) begin
            fp_q <= '0;
         end else if (core_hit && (fp_q == '0)) begin
            fp_q <= scan_cnt + 1'b1;
         end
         if (state == REPORT) rep_fp <= fp_q;
      end
   end

   assign first_pos = (state == REPORT) ? fp_q : rep_fp;
`else
   // The match strobe only feeds first_pos.
   logic unused_hit;
   assign unused_hit = core_hit;
`endif

   // Outputs decode from registers only.
   always_comb begin
      gnt       = ((state == LOAD) || (state == SCAN)) ? (N_REQ'(1) << last) : '0;
      busy      = (state != IDLE);
      done      = (state == REPORT);
      done_id   = rep_id;
      aborted   = rep_ab;
      match_cnt = (state == REPORT) ? core_cnt : rep_cnt;
   end

endmodule

// File: tb/tb_seq_det_sched.sv
// tb/tb_seq_det_sched.sv - scoreboard bench for seq_det_sched
module tb_seq_det_sched;

   localparam logic [11:0] DPAT = 12'b111011011011;
   localparam logic [63:0] ONES14 = 64'hFFFC_0000_0000_0000;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       cfg_we = 1'b0;
   logic [11:0] cfg_pat = '0;
   logic [3:0] req = '0;
   logic [3:0] bit_in = '0;
   logic [3:0] gnt;
   logic       busy, done, aborted;
   logic [1:0] done_id;
   logic [7:0] match_cnt;

   logic       s_cfg_we = 1'b0;
   logic [11:0] s_cfg_pat = '0;
   logic [3:0] s_req = '0;
   logic [3:0] s_bit = 4'hF;
   logic [3:0] s_gnt;
   logic       s_busy, s_done, s_aborted;
   logic [1:0] s_done_id;
   logic [3:0] s_match_cnt;
`ifdef SEQ_DET_SCHED_FIRST_POS_EN
   logic [6:0] first_pos, s_first_pos;
`endif

   typedef struct { int id; int cnt; int ab; int fp; } exp_t;
   exp_t exp_q[$];

   logic [63:0] stream [4];
   int gcnt [4];
   int cyc = 0;
   int total = 0;
   int bad = 0;

   seq_det_sched dut (
      .clk(clk), .reset(reset), .cfg_we(cfg_we), .cfg_pat(cfg_pat),
      .req(req), .bit_in(bit_in), .gnt(gnt), .busy(busy), .done(done),
      .done_id(done_id), .match_cnt(match_cnt),
`ifdef SEQ_DET_SCHED_FIRST_POS_EN
      .first_pos(first_pos),
`endif
      .aborted(aborted)
   );

   seq_det_sched #(.CNT_W(4)) u_sat (
      .clk(clk), .reset(reset), .cfg_we(s_cfg_we), .cfg_pat(s_cfg_pat),
      .req(s_req), .bit_in(s_bit), .gnt(s_gnt), .busy(s_busy), .done(s_done),
      .done_id(s_done_id), .match_cnt(s_match_cnt),
`ifdef SEQ_DET_SCHED_FIRST_POS_EN
      .first_pos(s_first_pos),
`endif
      .aborted(s_aborted)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // Bit k (1-based SCAN cycle) of a channel's stream is stream[c][64-k].
   initial begin
      for (int c = 0; c < 4; c++) begin
         stream[c] = '0;
         gcnt[c] = 0;
      end
      forever begin
         @(posedge clk);
         #1;
         for (int c = 0; c < 4; c++) begin
            if (gnt[c]) gcnt[c]++;
            else gcnt[c] = 0;
            bit_in[c] = (gcnt[c] >= 2 && gcnt[c] <= 65) ? stream[c][65 - gcnt[c]] : 1'b0;
         end
      end
   end

   // Monitor: every done pulse must match the oldest expected report.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (done) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_done", 1, 0);
            end else begin
               e = exp_q.pop_front();
               chk("done_id", int'(done_id), e.id);
               chk("match_cnt", int'(match_cnt), e.cnt);
               chk("aborted", int'(aborted), e.ab);
`ifdef SEQ_DET_SCHED_FIRST_POS_EN
               chk("first_pos", int'(first_pos), e.fp);
`endif
            end
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   task automatic wait_done(input int budget, output int at);
      at = -1;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         if (done) begin
            at = cyc;
            break;
         end
      end
      if (at < 0) chk("done_timeout", 0, 1);
   endtask

   task automatic cfg_write(input logic [11:0] v);
      @(posedge clk); #2;
      cfg_we = 1'b1;
      cfg_pat = v;
      @(posedge clk); #2;
      cfg_we = 1'b0;
   endtask

   task automatic run_job(input int ch, input int cnt, input int fp);
      int p, at;
      exp_q.push_back('{ch, cnt, 0, fp});
      @(posedge clk); #2;
      req[ch] = 1'b1;
      p = cyc;
      @(posedge clk); #2;
      chk("gnt_load", int'(gnt), 1 << ch);
      chk("busy_load", int'(busy), 1);
      wait_done(100, at);
      req[ch] = 1'b0;
      chk("done_time", at - p, 66);
   endtask

   task automatic run_abort(input int ch, input int k, input int cnt, input int fp);
      int p, at;
      exp_q.push_back('{ch, cnt, 1, fp});
      @(posedge clk); #2;
      req[ch] = 1'b1;
      p = cyc;
      repeat (k + 1) @(posedge clk);
      #2;
      req[ch] = 1'b0;
      wait_done(10, at);
      chk("abort_time", at - p, k + 2);
   endtask

   initial begin
      int at;
      int dt [5];

      repeat (3) @(posedge clk);
      #2;
      chk("rst_gnt", int'(gnt), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_done", int'(done), 0);
      chk("rst_done_id", int'(done_id), 0);
      chk("rst_match_cnt", int'(match_cnt), 0);
      chk("rst_aborted", int'(aborted), 0);
      reset = 1'b0;

      // default pattern, single occurrence
      stream[0] = {DPAT, 52'b0};
      run_job(0, 1, 12);

      // all-ones pattern, 14 ones overlap three times
      cfg_write(12'hFFF);
      stream[2] = ONES14;
      run_job(2, 3, 12);

      // write during LOAD applies to the next job only
      stream[1] = ONES14;
      fork
         run_job(1, 3, 12);
         begin
            repeat (2) @(posedge clk);
            #2;
            cfg_we = 1'b1;
            cfg_pat = 12'h000;
            @(posedge clk); #2;
            cfg_we = 1'b0;
         end
      join

      // all-zero pattern, fill gating leaves 64-11 matches
      stream[0] = '0;
      run_job(0, 53, 12);

      // write during SCAN: current job keeps old pattern
      cfg_write(DPAT);
      stream[3] = {DPAT, 52'b0};
      fork
         run_job(3, 1, 12);
         begin
            repeat (20) @(posedge clk);
            #2;
            cfg_we = 1'b1;
            cfg_pat = 12'hFFF;
            @(posedge clk); #2;
            cfg_we = 1'b0;
         end
      join
      stream[3] = ONES14;
      run_job(3, 3, 12);

      // aborts around the first possible match
      cfg_write(12'h000);
      stream[1] = '0;
      run_abort(1, 12, 0, 0);
      run_abort(1, 10, 0, 0);
      run_abort(1, 13, 1, 12);

      // reset mid-SCAN discards the job and restores everything
      stream[2] = '0;
      @(posedge clk); #2;
      req[2] = 1'b1;
      repeat (20) @(posedge clk);
      #2;
      reset = 1'b1;
      req = '0;
      @(posedge clk); #2;
      reset = 1'b0;
      chk("mid_rst_gnt", int'(gnt), 0);
      chk("mid_rst_busy", int'(busy), 0);
      chk("mid_rst_done_id", int'(done_id), 0);
      chk("mid_rst_match_cnt", int'(match_cnt), 0);
      chk("mid_rst_aborted", int'(aborted), 0);
      stream[0] = {DPAT, 52'b0};
      run_job(0, 1, 12);

      // all requesters held: fair order and 67-cycle spacing
      @(posedge clk); #2;
      reset = 1'b1;
      @(posedge clk); #2;
      reset = 1'b0;
      for (int c = 0; c < 4; c++) stream[c] = '0;
      exp_q.push_back('{0, 0, 0, 0});
      exp_q.push_back('{1, 0, 0, 0});
      exp_q.push_back('{2, 0, 0, 0});
      exp_q.push_back('{3, 0, 0, 0});
      exp_q.push_back('{0, 0, 0, 0});
      req = 4'hF;
      for (int i = 0; i < 5; i++) begin
         wait_done(100, dt[i]);
      end
      req = '0;
      for (int i = 1; i < 5; i++) begin
         chk("rr_spacing", dt[i] - dt[i-1], 67);
      end

      // narrow counter saturates
      @(posedge clk); #2;
      s_cfg_we = 1'b1;
      s_cfg_pat = 12'hFFF;
      @(posedge clk); #2;
      s_cfg_we = 1'b0;
      s_req = 4'b0001;
      at = -1;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (s_done) begin
            at = cyc;
            break;
         end
      end
      s_req = '0;
      chk("sat_seen", (at >= 0) ? 1 : 0, 1);
      chk("sat_cnt", int'(s_match_cnt), 15);

      repeat (5) @(posedge clk);
      chk("queue_empty", exp_q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
